// File: rtl/cmsdk_ahb_async_bridge_arbiter.sv
// Two-master AHB-Lite arbiter in front of the async bridge slave port.
// Losing address phases are parked in per-port pending registers; bursts are issued as single NONSEQ transfers.
module cmsdk_ahb_async_bridge_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic                  HCLKS,
  input  logic                  HRESETS,
  input  logic [1:0]            HTRANS0,
  input  logic [ADDR_WIDTH-1:0] HADDR0,
  input  logic                  HWRITE0,
  input  logic [2:0]            HSIZE0,
  input  logic [3:0]            HPROT0,
  input  logic [DATA_WIDTH-1:0] HWDATA0,
  output logic                  HREADYOUT0,
  output logic                  HRESP0,
  input  logic [1:0]            HTRANS1,
  input  logic [ADDR_WIDTH-1:0] HADDR1,
  input  logic                  HWRITE1,
  input  logic [2:0]            HSIZE1,
  input  logic [3:0]            HPROT1,
  input  logic [DATA_WIDTH-1:0] HWDATA1,
  output logic                  HREADYOUT1,
  output logic                  HRESP1,
  output logic [DATA_WIDTH-1:0] HRDATA,
  output logic [1:0]            HTRANSM,
  output logic [ADDR_WIDTH-1:0] HADDRM,
  output logic                  HWRITEM,
  output logic [2:0]            HSIZEM,
  output logic [3:0]            HPROTM,
  output logic [DATA_WIDTH-1:0] HWDATAM,
  output logic                  HMASTERM,
  input  logic                  HREADYOUTM,
  input  logic                  HRESPM,
  input  logic [DATA_WIDTH-1:0] HRDATAM
);

  logic                  pend0, pend1;
  logic [ADDR_WIDTH-1:0] pend_addr0, pend_addr1;
  logic                  pend_write0, pend_write1;
  logic [2:0]            pend_size0, pend_size1;
  logic [3:0]            pend_prot0, pend_prot1;

  logic                  dvalid, downer, last_grant;

  logic [ADDR_WIDTH-1:0] addr_q;
  logic                  write_q, master_q;
  logic [2:0]            size_q;
  logic [3:0]            prot_q;

  logic ready0, ready1, resp0, resp1;
  logic live0, live1, req0, req1;
  logic both, winner, grant, grant0, grant1;

  logic [ADDR_WIDTH-1:0] sel_addr;
  logic                  sel_write;
  logic [2:0]            sel_size;
  logic [3:0]            sel_prot;

  // Only HTRANS[1] matters: IDLE and BUSY are never forwarded.
  logic unused_trans;
  assign unused_trans = HTRANS0[0] ^ HTRANS1[0];

  always_comb begin
    ready0 = 1'b1;
    resp0  = 1'b0;
    if (dvalid && !downer) begin
      ready0 = HREADYOUTM;
      resp0  = HRESPM;
    end else if (pend0) begin
      ready0 = 1'b0;
    end
  end

  always_comb begin
    ready1 = 1'b1;
    resp1  = 1'b0;
    if (dvalid && downer) begin
      ready1 = HREADYOUTM;
      resp1  = HRESPM;
    end else if (pend1) begin
      ready1 = 1'b0;
    end
  end

  assign live0 = HTRANS0[1] & ready0 & ~pend0;
  assign live1 = HTRANS1[1] & ready1 & ~pend1;
  assign req0  = live0 | pend0;
  assign req1  = live1 | pend1;
  assign both  = req0 & req1;

  // Round-robin hands a tie to the port that did not win last time.
  assign winner = both ? (FIXED_PRIO ? 1'b0 : ~last_grant) : req1;
  assign grant  = HREADYOUTM & (req0 | req1) & ~HRESETS;
  assign grant0 = grant & ~winner;
  assign grant1 = grant & winner;

  always_comb begin
    if (winner) begin
      sel_addr  = pend1 ? pend_addr1  : HADDR1;
      sel_write = pend1 ? pend_write1 : HWRITE1;
      sel_size  = pend1 ? pend_size1  : HSIZE1;
      sel_prot  = pend1 ? pend_prot1  : HPROT1;
    end else begin
      sel_addr  = pend0 ? pend_addr0  : HADDR0;
      sel_write = pend0 ? pend_write0 : HWRITE0;
      sel_size  = pend0 ? pend_size0  : HSIZE0;
      sel_prot  = pend0 ? pend_prot0  : HPROT0;
    end
  end

  always_ff @(posedge HCLKS or posedge HRESETS) begin
    if (HRESETS) begin
      pend0       <= 1'b0;
      pend1       <= 1'b0;
      pend_addr0  <= '0;
      pend_addr1  <= '0;
      pend_write0 <= 1'b0;
      pend_write1 <= 1'b0;
      pend_size0  <= '0;
      pend_size1  <= '0;
      pend_prot0  <= '0;
      pend_prot1  <= '0;
      dvalid      <= 1'b0;
      downer      <= 1'b0;
      last_grant  <= 1'b1;
      addr_q      <= '0;
      write_q     <= 1'b0;
      size_q      <= '0;
      prot_q      <= '0;
      master_q    <= 1'b0;
    end else begin
      if (grant0) begin
        pend0 <= 1'b0;
      end else if (live0) begin
        pend0       <= 1'b1;
        pend_addr0  <= HADDR0;
        pend_write0 <= HWRITE0;
        pend_size0  <= HSIZE0;
        pend_prot0  <= HPROT0;
      end

      if (grant1) begin
        pend1 <= 1'b0;
      end else if (live1) begin
        pend1       <= 1'b1;
        pend_addr1  <= HADDR1;
        pend_write1 <= HWRITE1;
        pend_size1  <= HSIZE1;
        pend_prot1  <= HPROT1;
      end

      if (grant) begin
        last_grant <= winner;
        addr_q     <= sel_addr;
        write_q    <= sel_write;
        size_q     <= sel_size;
        prot_q     <= sel_prot;
        master_q   <= winner;
      end

      if (HREADYOUTM) begin
        dvalid <= grant;
        downer <= winner;
      end
    end
  end

  assign HTRANSM  = grant ? 2'b10 : 2'b00;
  assign HADDRM   = grant ? sel_addr  : addr_q;
  assign HWRITEM  = grant ? sel_write : write_q;
  assign HSIZEM   = grant ? sel_size  : size_q;
  assign HPROTM   = grant ? sel_prot  : prot_q;
  assign HMASTERM = grant ? winner    : master_q;

  assign HWDATAM    = downer ? HWDATA1 : HWDATA0;
  assign HRDATA     = HRDATAM;
  assign HREADYOUT0 = ready0;
  assign HREADYOUT1 = ready1;
  assign HRESP0     = resp0;
  assign HRESP1     = resp1;

endmodule

// File: tb/tb_cmsdk_ahb_async_bridge_arbiter.sv
// Directed bench: a round-robin and a fixed-priority arbiter share one stimulus stream.
module tb_cmsdk_ahb_async_bridge_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic [1:0]  htrans0, htrans1;
  logic [31:0] haddr0, haddr1, hwdata0, hwdata1, hrdatam;
  logic        hwrite0, hwrite1, hreadyoutm, hrespm;
  logic [2:0]  hsize0, hsize1;
  logic [3:0]  hprot0, hprot1;

  logic        r_hreadyout0, r_hreadyout1, r_hresp0, r_hresp1, r_hwritem, r_hmasterm;
  logic [31:0] r_hrdata, r_haddrm, r_hwdatam;
  logic [1:0]  r_htransm;
  logic [2:0]  r_hsizem;
  logic [3:0]  r_hprotm;

  logic        f_hreadyout0, f_hreadyout1, f_hresp0, f_hresp1, f_hwritem, f_hmasterm;
  logic [31:0] f_hrdata, f_haddrm, f_hwdatam;
  logic [1:0]  f_htransm;
  logic [2:0]  f_hsizem;
  logic [3:0]  f_hprotm;

  int tests = 0;
  int fails = 0;
  int rr0, rr1, fx0;

  always #5 clk = ~clk;

  cmsdk_ahb_async_bridge_arbiter #(.FIXED_PRIO(1'b0)) u_rr (
    .HCLKS(clk), .HRESETS(rst),
    .HTRANS0(htrans0), .HADDR0(haddr0), .HWRITE0(hwrite0), .HSIZE0(hsize0), .HPROT0(hprot0),
    .HWDATA0(hwdata0), .HREADYOUT0(r_hreadyout0), .HRESP0(r_hresp0),
    .HTRANS1(htrans1), .HADDR1(haddr1), .HWRITE1(hwrite1), .HSIZE1(hsize1), .HPROT1(hprot1),
    .HWDATA1(hwdata1), .HREADYOUT1(r_hreadyout1), .HRESP1(r_hresp1),
    .HRDATA(r_hrdata), .HTRANSM(r_htransm), .HADDRM(r_haddrm), .HWRITEM(r_hwritem),
    .HSIZEM(r_hsizem), .HPROTM(r_hprotm), .HWDATAM(r_hwdatam), .HMASTERM(r_hmasterm),
    .HREADYOUTM(hreadyoutm), .HRESPM(hrespm), .HRDATAM(hrdatam)
  );

  cmsdk_ahb_async_bridge_arbiter #(.FIXED_PRIO(1'b1)) u_fx (
    .HCLKS(clk), .HRESETS(rst),
    .HTRANS0(htrans0), .HADDR0(haddr0), .HWRITE0(hwrite0), .HSIZE0(hsize0), .HPROT0(hprot0),
    .HWDATA0(hwdata0), .HREADYOUT0(f_hreadyout0), .HRESP0(f_hresp0),
    .HTRANS1(htrans1), .HADDR1(haddr1), .HWRITE1(hwrite1), .HSIZE1(hsize1), .HPROT1(hprot1),
    .HWDATA1(hwdata1), .HREADYOUT1(f_hreadyout1), .HRESP1(f_hresp1),
    .HRDATA(f_hrdata), .HTRANSM(f_htransm), .HADDRM(f_haddrm), .HWRITEM(f_hwritem),
    .HSIZEM(f_hsizem), .HPROTM(f_hprotm), .HWDATAM(f_hwdatam), .HMASTERM(f_hmasterm),
    .HREADYOUTM(hreadyoutm), .HRESPM(hrespm), .HRDATAM(hrdatam)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic idle_inputs();
    htrans0 = 2'b00; haddr0 = '0; hwrite0 = 1'b0; hsize0 = 3'd0; hprot0 = 4'd0; hwdata0 = '0;
    htrans1 = 2'b00; haddr1 = '0; hwrite1 = 1'b0; hsize1 = 3'd0; hprot1 = 4'd0; hwdata1 = '0;
    hreadyoutm = 1'b1; hrespm = 1'b0; hrdatam = '0;
  endtask

  task automatic do_reset();
    idle_inputs();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    rst = 1'b1;
    idle_inputs();
    nxt();
    #1;
    chk("rst_ready0", r_hreadyout0, 1);
    chk("rst_ready1", r_hreadyout1, 1);
    chk("rst_resp0", r_hresp0, 0);
    chk("rst_trans", r_htransm, 0);
    chk("rst_addr", r_haddrm, 0);
    chk("rst_master", r_hmasterm, 0);
    chk("rst_last", u_rr.last_grant, 1);
    rst = 1'b0;

    // Single uncontended M0 read
    htrans0 = 2'b10; haddr0 = 32'h2000_0010;
    #1;
    chk("rd_trans", r_htransm, 2);
    chk("rd_addr", r_haddrm, 32'h2000_0010);
    chk("rd_master", r_hmasterm, 0);
    chk("rd_m1_ready", r_hreadyout1, 1);
    nxt();
    htrans0 = 2'b00; hrdatam = 32'hCAFE_0001;
    #1;
    chk("rd_hrdata", r_hrdata, 32'hCAFE_0001);
    chk("rd_ready0", r_hreadyout0, 1);
    chk("rd_idle_trans", r_htransm, 0);
    chk("rd_addr_hold", r_haddrm, 32'h2000_0010);
    nxt();

    // Simultaneous writes after reset
    do_reset();
    htrans0 = 2'b10; hwrite0 = 1'b1; haddr0 = 32'h100;
    htrans1 = 2'b10; hwrite1 = 1'b1; haddr1 = 32'h200; hsize1 = 3'd2; hprot1 = 4'd3;
    #1;
    chk("tie_trans", r_htransm, 2);
    chk("tie_master", r_hmasterm, 0);
    chk("tie_addr", r_haddrm, 32'h100);
    nxt();
    htrans0 = 2'b00; haddr1 = 32'hBAD; hsize1 = 3'd0; hprot1 = 4'd0;
    hwdata0 = 32'h1111_1111; hwdata1 = 32'h2222_2222;
    #1;
    chk("tie_pend1", u_rr.pend1, 1);
    chk("tie_stall1", r_hreadyout1, 0);
    chk("tie_wdata0", r_hwdatam, 32'h1111_1111);
    chk("tie_m1_trans", r_htransm, 2);
    chk("tie_m1_master", r_hmasterm, 1);
    chk("tie_m1_addr", r_haddrm, 32'h200);
    chk("tie_m1_size", r_hsizem, 2);
    chk("tie_m1_prot", r_hprotm, 3);
    chk("tie_m1_write", r_hwritem, 1);
    nxt();
    htrans1 = 2'b00;
    #1;
    chk("tie_last", u_rr.last_grant, 1);
    chk("tie_wdata1", r_hwdatam, 32'h2222_2222);
    chk("tie_ready1", r_hreadyout1, 1);
    chk("tie_pend1_clr", u_rr.pend1, 0);
    nxt();

    // Back-to-back streaming from both masters
    do_reset();
    htrans0 = 2'b10; haddr0 = 32'h1000;
    htrans1 = 2'b10; haddr1 = 32'h3000;
    rr0 = 0; rr1 = 0; fx0 = 0;
    for (int i = 0; i < 8; i++) begin
      #1;
      chk("rr_trans", r_htransm, 2);
      chk("rr_order", r_hmasterm, i % 2);
      chk("fx_master", f_hmasterm, 0);
      if (r_htransm == 2'b10) begin
        if (r_hmasterm) rr1++;
        else rr0++;
      end
      if (f_htransm == 2'b10 && f_hmasterm == 1'b0) fx0++;
      nxt();
    end
    chk("rr_count0", rr0, 4);
    chk("rr_count1", rr1, 4);
    chk("fx_count0", fx0, 8);

    // Two-cycle error response on an M1 write
    do_reset();
    htrans1 = 2'b10; hwrite1 = 1'b1; haddr1 = 32'h300;
    #1;
    chk("err_grant", r_hmasterm, 1);
    nxt();
    htrans1 = 2'b00; hreadyoutm = 1'b0; hrespm = 1'b1;
    #1;
    chk("err1_resp1", r_hresp1, 1);
    chk("err1_ready1", r_hreadyout1, 0);
    chk("err1_resp0", r_hresp0, 0);
    chk("err1_ready0", r_hreadyout0, 1);
    nxt();
    hreadyoutm = 1'b1;
    #1;
    chk("err2_resp1", r_hresp1, 1);
    chk("err2_ready1", r_hreadyout1, 1);
    chk("err2_resp0", r_hresp0, 0);
    nxt();
    hrespm = 1'b0;
    #1;
    chk("err_done_resp1", r_hresp1, 0);

    // Bridge stall while M1 posts a request
    hreadyoutm = 1'b0; htrans1 = 2'b10; hwrite1 = 1'b0; haddr1 = 32'h400;
    #1;
    chk("stall0_trans", r_htransm, 0);
    nxt();
    for (int i = 1; i < 5; i++) begin
      #1;
      chk("stall_trans", r_htransm, 0);
      chk("stall_ready1", r_hreadyout1, 0);
      nxt();
    end
    hreadyoutm = 1'b1;
    #1;
    chk("stall_grant_trans", r_htransm, 2);
    chk("stall_grant_master", r_hmasterm, 1);
    chk("stall_grant_addr", r_haddrm, 32'h400);
    nxt();
    htrans1 = 2'b00;
    nxt();

    // Asynchronous reset while M1 is pending behind a stall
    hreadyoutm = 1'b0; htrans1 = 2'b10; haddr1 = 32'h500;
    nxt();
    #1;
    chk("pre_rst_pend1", u_rr.pend1, 1);
    chk("pre_rst_ready1", r_hreadyout1, 0);
    #1;
    rst = 1'b1;
    hreadyoutm = 1'b1;
    #1;
    chk("arst_ready0", r_hreadyout0, 1);
    chk("arst_ready1", r_hreadyout1, 1);
    chk("arst_trans", r_htransm, 0);
    chk("arst_pend1", u_rr.pend1, 0);
    nxt();
    rst = 1'b0;
    htrans0 = 2'b10; haddr0 = 32'h600;
    #1;
    chk("post_rst_trans", r_htransm, 2);
    chk("post_rst_master", r_hmasterm, 0);
    chk("post_rst_fx_master", f_hmasterm, 0);
    nxt();
    idle_inputs();
    nxt();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
